// File: rtl/multi_bank_cmd_scheduler_pkg.sv
// Shared types for the multi-bank command scheduler: bank FSM states, issued
// commands and the read/write direction mode.
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

package usertype;

  localparam int FSM_WIDTH2    = 4;
  localparam int SCH_CMD_WIDTH = 3;

  typedef enum logic [FSM_WIDTH2-1:0] {
    B_IDLE          = 4'd0,
    B_ACT_STANDBY   = 4'd1,
    B_ACTIVE_CHECK  = 4'd2,
    B_ACTIVE        = 4'd3,
    B_READ_CHECK    = 4'd4,
    B_READ          = 4'd5,
    B_WRITE_CHECK   = 4'd6,
    B_WRITE         = 4'd7,
    B_PRE_CHECK     = 4'd8,
    B_PRE           = 4'd9,
    B_REFRESH_CHECK = 4'd10,
    B_REFRESH       = 4'd11
  } bank_state_t;

  typedef enum logic [SCH_CMD_WIDTH-1:0] {
    ATCMD_NOP       = 3'd0,
    ATCMD_ACTIVE    = 3'd1,
    ATCMD_READ      = 3'd2,
    ATCMD_WRITE     = 3'd3,
    ATCMD_PRECHARGE = 3'd4,
    ATCMD_REFRESH   = 3'd5
  } sch_cmd_t;

  typedef enum logic {M_WRITE = 1'b0, M_READ = 1'b1} sch_mode_t;

  function automatic sch_cmd_t state_to_cmd(input bank_state_t s);
    case (s)
      B_ACTIVE:        return ATCMD_ACTIVE;
      B_READ:          return ATCMD_READ;
      B_WRITE:         return ATCMD_WRITE;
      B_PRE:           return ATCMD_PRECHARGE;
      B_REFRESH_CHECK: return ATCMD_REFRESH;
      default:         return ATCMD_NOP;
    endcase
  endfunction

  function automatic logic is_pending(input bank_state_t s);
    return s inside {B_ACTIVE_CHECK, B_ACTIVE, B_READ_CHECK, B_READ, B_WRITE_CHECK,
                     B_WRITE, B_PRE_CHECK, B_PRE, B_REFRESH_CHECK};
  endfunction

endpackage

// File: rtl/multi_bank_cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module sch_rr_arbiter #(
  parameter int NUM_BANKS = 8,
  parameter int IDX_BITS  = $clog2(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] req,
  input  logic [IDX_BITS-1:0]  ptr,
  output logic [NUM_BANKS-1:0] gnt,
  output logic [IDX_BITS-1:0]  idx,
  output logic                 vld
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    // Scan from farthest to nearest so the bank closest to ptr overwrites the rest.
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_BANKS) j = j - NUM_BANKS;
      if (req[j]) begin
        idx = IDX_BITS'(j);
        vld = 1'b1;
      end
    end
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/multi_bank_cmd_scheduler.sv
// Multi-bank command scheduler: class priority, per-class round-robin, burst
// grouping. Define SCH_AGE_OVERRIDE_EN to build the age-based starvation override.
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

module multi_bank_cmd_scheduler
  import usertype::*;
#(
  parameter int NUM_BANKS     = 8,
  parameter int ADDR_BITS     = `ADDR_BITS,
  parameter int BA_BITS       = $clog2(NUM_BANKS),
  parameter int BURST_LIMIT   = 4,
  parameter int AGE_WIDTH     = 8,
  parameter int AGE_THRESHOLD = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  isu_fifo_full,
  input  logic [NUM_BANKS*FSM_WIDTH2-1:0]       ba_state,
  input  logic [NUM_BANKS*ADDR_BITS-1:0]        ba_addr,
  output logic [NUM_BANKS-1:0]                  ba_stall,
  output logic [SCH_CMD_WIDTH+ADDR_BITS+BA_BITS-1:0] sch_out,
  output logic                                  sch_issue
);

  localparam int BCW = $clog2(BURST_LIMIT + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST_LIMIT);

  bank_state_t            st [NUM_BANKS];
  logic [ADDR_BITS-1:0]   ad [NUM_BANKS];
  logic [NUM_BANKS-1:0]   pend, idle, ref_req, pre_req, act_req, rd_req, wr_req, rd_pend, wr_pend;
  logic [NUM_BANKS-1:0]   cur_req, opp_req, hi_req, lo_req;
  logic                   swap;

  sch_mode_t              mode;
  logic [BCW-1:0]         burst_cnt;
  logic [BA_BITS-1:0]     rr_ptr;

  always_comb begin
    pend = '0; idle = '0; ref_req = '0; pre_req = '0; act_req = '0;
    rd_req = '0; wr_req = '0; rd_pend = '0; wr_pend = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      st[i]      = bank_state_t'(ba_state[i*FSM_WIDTH2 +: FSM_WIDTH2]);
      ad[i]      = ba_addr[i*ADDR_BITS +: ADDR_BITS];
      pend[i]    = is_pending(st[i]);
      idle[i]    = (st[i] == B_IDLE) || (st[i] == B_ACT_STANDBY);
      ref_req[i] = (st[i] == B_REFRESH_CHECK);
      pre_req[i] = (st[i] == B_PRE);
      act_req[i] = (st[i] == B_ACTIVE);
      rd_req[i]  = (st[i] == B_READ);
      wr_req[i]  = (st[i] == B_WRITE);
      rd_pend[i] = (st[i] == B_READ)  || (st[i] == B_READ_CHECK);
      wr_pend[i] = (st[i] == B_WRITE) || (st[i] == B_WRITE_CHECK);
    end
  end

  // After a full burst the opposite direction is promoted, but only if it has work queued.
  always_comb begin
    cur_req = (mode == M_WRITE) ? wr_req : rd_req;
    opp_req = (mode == M_WRITE) ? rd_req : wr_req;
    swap    = (burst_cnt == BURST_MAX) && ((mode == M_WRITE) ? |rd_pend : |wr_pend);
    hi_req  = swap ? opp_req : cur_req;
    lo_req  = swap ? cur_req : opp_req;
  end

  logic [NUM_BANKS-1:0] ref_gnt, pre_gnt, act_gnt, hi_gnt, lo_gnt;
  logic [BA_BITS-1:0]   ref_idx, pre_idx, act_idx, hi_idx, lo_idx;
  logic                 ref_vld, pre_vld, act_vld, hi_vld, lo_vld;

  sch_rr_arbiter #(.NUM_BANKS(NUM_BANKS), .IDX_BITS(BA_BITS)) u_arb_ref
    (.req(ref_req), .ptr(rr_ptr), .gnt(ref_gnt), .idx(ref_idx), .vld(ref_vld));
  sch_rr_arbiter #(.NUM_BANKS(NUM_BANKS), .IDX_BITS(BA_BITS)) u_arb_pre
    (.req(pre_req), .ptr(rr_ptr), .gnt(pre_gnt), .idx(pre_idx), .vld(pre_vld));
  sch_rr_arbiter #(.NUM_BANKS(NUM_BANKS), .IDX_BITS(BA_BITS)) u_arb_act
    (.req(act_req), .ptr(rr_ptr), .gnt(act_gnt), .idx(act_idx), .vld(act_vld));
  sch_rr_arbiter #(.NUM_BANKS(NUM_BANKS), .IDX_BITS(BA_BITS)) u_arb_hi
    (.req(hi_req),  .ptr(rr_ptr), .gnt(hi_gnt),  .idx(hi_idx),  .vld(hi_vld));
  sch_rr_arbiter #(.NUM_BANKS(NUM_BANKS), .IDX_BITS(BA_BITS)) u_arb_lo
    (.req(lo_req),  .ptr(rr_ptr), .gnt(lo_gnt),  .idx(lo_idx),  .vld(lo_vld));

  logic [NUM_BANKS-1:0] gnt_oh;
  logic [BA_BITS-1:0]   gnt_idx;
  logic                 gnt_vld;

`ifdef SCH_AGE_OVERRIDE_EN
  localparam logic [AGE_WIDTH-1:0] AGE_THR = AGE_WIDTH'(AGE_THRESHOLD);
  logic [AGE_WIDTH-1:0] age [NUM_BANKS];
  logic [AGE_WIDTH-1:0] stv_best;
  logic [NUM_BANKS-1:0] stv_gnt;
  logic [BA_BITS-1:0]   stv_idx;
  logic                 stv_vld;

  // Oldest ready starved bank wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    stv_best = '0;
    stv_idx  = '0;
    stv_vld  = 1'b0;
    stv_gnt  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (st[i] inside {B_ACTIVE, B_READ, B_WRITE, B_PRE, B_REFRESH_CHECK} &&
          age[i] >= AGE_THR && (!stv_vld || age[i] > stv_best)) begin
        stv_best = age[i];
        stv_idx  = BA_BITS'(i);
        stv_vld  = 1'b1;
      end
    end
    if (stv_vld) stv_gnt[stv_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the age array is reset element by element; it is state, not storage.
      for (int i = 0; i < NUM_BANKS; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (idle[i] || gnt_oh[i])         age[i] <= '0;
        else if (pend[i] && age[i] != '1) age[i] <= age[i] + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (!isu_fifo_full) begin
      if (ref_vld) begin
        gnt_oh = ref_gnt; gnt_idx = ref_idx; gnt_vld = 1'b1;
      end
`ifdef SCH_AGE_OVERRIDE_EN
      else if (stv_vld) begin
        gnt_oh = stv_gnt; gnt_idx = stv_idx; gnt_vld = 1'b1;
      end
`endif
      else if (pre_vld) begin
        gnt_oh = pre_gnt; gnt_idx = pre_idx; gnt_vld = 1'b1;
      end else if (act_vld) begin
        gnt_oh = act_gnt; gnt_idx = act_idx; gnt_vld = 1'b1;
      end else if (hi_vld) begin
        gnt_oh = hi_gnt;  gnt_idx = hi_idx;  gnt_vld = 1'b1;
      end else if (lo_vld) begin
        gnt_oh = lo_gnt;  gnt_idx = lo_idx;  gnt_vld = 1'b1;
      end
    end
  end

  sch_cmd_t  gnt_cmd;
  sch_mode_t gnt_dir;
  logic      gnt_col;

  always_comb begin
    gnt_cmd  = state_to_cmd(st[gnt_idx]);
    gnt_col  = (gnt_cmd == ATCMD_READ) || (gnt_cmd == ATCMD_WRITE);
    gnt_dir  = (gnt_cmd == ATCMD_READ) ? M_READ : M_WRITE;
    ba_stall = rst ? '1 : ~gnt_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      sch_issue <= 1'b0;
      sch_out   <= {ATCMD_NOP, ADDR_BITS'(0), BA_BITS'(0)};
      rr_ptr    <= '0;
      mode      <= M_WRITE;
      burst_cnt <= '0;
    end else begin
      sch_issue <= gnt_vld;
      if (gnt_vld) begin
        sch_out <= {gnt_cmd, ad[gnt_idx], gnt_idx};
        rr_ptr  <= (gnt_idx == BA_BITS'(NUM_BANKS - 1)) ? '0 : gnt_idx + BA_BITS'(1);
        if (gnt_col) begin
          if (gnt_dir == mode) begin
            if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + BCW'(1);
          end else begin
            mode      <= gnt_dir;
            burst_cnt <= BCW'(1);
          end
        end
      end
    end
  end

endmodule
